// File: rtl/muldiv_if.sv
// Handshake/operand bundle between the EX stage and the iterative RV32M mul/div unit.
// The master drives the request side; the slave returns busy, done and result.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, funct3, op_a, op_b, flush,
                    input  busy, done, result);
    modport slave  (input  start, funct3, op_a, op_b, flush,
                    output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Operands are converted to magnitudes on start, the sign is re-applied in FIXUP.
// Optional feature: define MULDIV_FAST_MUL_EN to route multiplies through a
// single-cycle 64-bit product in FIXUP instead of the 32-iteration path.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one multiply/divide iteration per cycle, 32 cycles
// FIXUP | apply result sign, select word, register result
// DONE  | done pulse, result valid; a new start is accepted here
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic              neg_q, neg_d;
    logic              special_q, special_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              a_signed, b_signed, is_div;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] prod_src, prod_sgn;
    logic [XLEN-1:0]   quo_sgn, rem_sgn;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
`endif

    // Operand signedness and magnitudes for the request presented this cycle
    always_comb begin
        is_div   = bus.funct3[2];
        a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                   (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                   (bus.funct3 == 3'b110);
        abs_a    = (a_signed && bus.op_a[XLEN-1]) ? (~bus.op_a + 1'b1) : bus.op_a;
        abs_b    = (b_signed && bus.op_b[XLEN-1]) ? (~bus.op_b + 1'b1) : bus.op_b;
    end

    // Next-state, datapath iteration and result fixup
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        f3_d      = f3_q;
        a_d       = a_q;
        b_d       = b_q;
        prod_d    = prod_q;
        neg_d     = neg_q;
        special_d = special_q;
        result_d  = result_q;

        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);
        div_shift = prod_q[2*XLEN-1:XLEN-1];
        div_ge    = div_shift >= {1'b0, b_q};
        div_diff  = div_shift[XLEN-1:0] - b_q;

`ifdef MULDIV_FAST_MUL_EN
        fast_prod = {{XLEN{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q};
        prod_src  = f3_q[2] ? prod_q : fast_prod;
`else
        prod_src  = prod_q;
`endif
        prod_sgn  = neg_q ? (~prod_src + 1'b1) : prod_src;
        quo_sgn   = neg_q ? (~prod_q[XLEN-1:0] + 1'b1) : prod_q[XLEN-1:0];
        rem_sgn   = neg_q ? (~prod_q[2*XLEN-1:XLEN] + 1'b1) : prod_q[2*XLEN-1:XLEN];

        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        f3_d      = bus.funct3;
                        a_d       = abs_a;
                        b_d       = abs_b;
                        cnt_d     = '0;
                        special_d = 1'b0;
                        case (bus.funct3)
                            3'b001:  neg_d = bus.op_a[XLEN-1] ^ bus.op_b[XLEN-1];
                            3'b010:  neg_d = bus.op_a[XLEN-1];
                            3'b100:  neg_d = bus.op_a[XLEN-1] ^ bus.op_b[XLEN-1];
                            3'b110:  neg_d = bus.op_a[XLEN-1];
                            default: neg_d = 1'b0;
                        endcase
                        if (is_div && bus.op_b == '0) begin
                            // Divide by zero: all-ones quotient, dividend as remainder
                            special_d = 1'b1;
                            prod_d    = {{XLEN{1'b0}}, bus.funct3[1] ? bus.op_a : {XLEN{1'b1}}};
                            state_d   = FIXUP;
                        end else if (is_div && !bus.funct3[0] &&
                                     bus.op_a == {1'b1, {(XLEN-1){1'b0}}} &&
                                     bus.op_b == {XLEN{1'b1}}) begin
                            // Signed overflow: quotient is the dividend, remainder zero
                            special_d = 1'b1;
                            prod_d    = {{XLEN{1'b0}}, bus.funct3[1] ? {XLEN{1'b0}} : bus.op_a};
                            state_d   = FIXUP;
                        end else if (is_div) begin
                            prod_d  = {{XLEN{1'b0}}, abs_a};
                            state_d = CALC;
                        end else begin
                            prod_d  = {{XLEN{1'b0}}, abs_b};
`ifdef MULDIV_FAST_MUL_EN
                            state_d = FIXUP;
`else
                            state_d = CALC;
`endif
                        end
                    end else if (state_q == DONE) begin
                        state_d = IDLE;
                    end
                end
                CALC: begin
                    if (f3_q[2]) begin
                        prod_d = div_ge ? {div_diff, prod_q[XLEN-2:0], 1'b1}
                                        : {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
                    end else begin
                        prod_d = {mul_sum, prod_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN-1)) state_d = FIXUP;
                end
                FIXUP: begin
                    if (special_q)
                        result_d = prod_q[XLEN-1:0];
                    else if (f3_q[2])
                        result_d = f3_q[1] ? rem_sgn : quo_sgn;
                    else
                        result_d = (f3_q[1:0] == 2'b00) ? prod_sgn[XLEN-1:0]
                                                        : prod_sgn[2*XLEN-1:XLEN];
                    state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == CALC) || (state_d == FIXUP);
        done_d = (state_d == DONE);
    end

    // State and datapath registers, asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            f3_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            prod_q    <= '0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            f3_q      <= f3_d;
            a_q       <= a_d;
            b_q       <= b_d;
            prod_q    <= prod_d;
            neg_q     <= neg_d;
            special_q <= special_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus flush, busy-start and
// asynchronous-reset sequences.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    muldiv_if u_if ();
    muldiv_unit dut (.clk(clk), .rst(rst), .bus(u_if));

    always #5 clk = ~clk;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;
    localparam int SPC_LAT = 2;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Start an op; optionally pulse start again (ignored) after ign_at edges.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input int ign_at, output int lat, output int busy_n);
        u_if.start  = 1'b1;
        u_if.funct3 = f3;
        u_if.op_a   = a;
        u_if.op_b   = b;
        @(posedge clk);
        #1;
        u_if.start  = 1'b0;
        u_if.op_a   = $urandom;
        u_if.op_b   = $urandom;
        u_if.funct3 = 3'($urandom);
        lat    = 1;
        busy_n = u_if.busy ? 1 : 0;
        while (!u_if.done && lat < 100) begin
            if (lat == ign_at) begin
                u_if.start  = 1'b1;
                u_if.funct3 = 3'b000;
                u_if.op_a   = 32'd1;
                u_if.op_b   = 32'd1;
            end
            @(posedge clk);
            #1;
            u_if.start = 1'b0;
            lat++;
            if (u_if.busy) busy_n++;
        end
    endtask

    vec_t vecs[$];

    initial begin
        int lat, busy_n, i;
        logic [31:0] held;

        vecs.push_back('{"mul_7x6",    3'b000, 32'd7,         32'd6,         32'd42,         MUL_LAT});
        vecs.push_back('{"mul_neg",    3'b000, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFA, MUL_LAT});
        vecs.push_back('{"mulh_m1m1",  3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT});
        vecs.push_back('{"mulhu_max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT});
        vecs.push_back('{"mulhsu_m1",  3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, MUL_LAT});
        vecs.push_back('{"div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT});
        vecs.push_back('{"rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT});
        vecs.push_back('{"divu_100_7", 3'b101, 32'd100,       32'd7,         32'd14,        DIV_LAT});
        vecs.push_back('{"remu_100_7", 3'b111, 32'd100,       32'd7,         32'd2,         DIV_LAT});
        vecs.push_back('{"div_7_m2",   3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT});
        vecs.push_back('{"rem_7_m2",   3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         DIV_LAT});
        vecs.push_back('{"divu_max_1", 3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, DIV_LAT});
        vecs.push_back('{"div_by0",    3'b100, 32'd1234,      32'd0,         32'hFFFF_FFFF, SPC_LAT});
        vecs.push_back('{"divu_by0",   3'b101, 32'd9,         32'd0,         32'hFFFF_FFFF, SPC_LAT});
        vecs.push_back('{"remu_by0",   3'b111, 32'd5,         32'd0,         32'd5,         SPC_LAT});
        vecs.push_back('{"div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT});
        vecs.push_back('{"rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPC_LAT});

        u_if.start = 1'b0; u_if.flush = 1'b0; u_if.funct3 = '0;
        u_if.op_a = '0; u_if.op_b = '0;
        #12;
        check("rst_busy",   {31'd0, u_if.busy}, 32'd0);
        check("rst_done",   {31'd0, u_if.done}, 32'd0);
        check("rst_result", u_if.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (i = 0; i < vecs.size(); i++) begin
            do_op(vecs[i].f3, vecs[i].a, vecs[i].b, -1, lat, busy_n);
            check({vecs[i].name, "_res"},  u_if.result, vecs[i].exp_res);
            check({vecs[i].name, "_lat"},  32'(lat), 32'(vecs[i].exp_lat));
            check({vecs[i].name, "_busy"}, 32'(busy_n), 32'(vecs[i].exp_lat - 1));
            // done is a single-cycle pulse; result held afterwards
            held = u_if.result;
            @(posedge clk); #1;
            check({vecs[i].name, "_done1"}, {31'd0, u_if.done}, 32'd0);
            @(posedge clk); #1;
            check({vecs[i].name, "_hold"}, u_if.result, vecs[i].exp_res);
        end

        // Back-to-back: new start accepted in DONE
        do_op(3'b101, 32'd50, 32'd5, -1, lat, busy_n);
        do_op(3'b111, 32'd50, 32'd7, -1, lat, busy_n);
        check("b2b_res", u_if.result, 32'd1);
        check("b2b_lat", 32'(lat), 32'(DIV_LAT));

        // start while busy is ignored
        do_op(3'b101, 32'd100, 32'd7, 5, lat, busy_n);
        check("ign_res", u_if.result, 32'd14);
        check("ign_lat", 32'(lat), 32'(DIV_LAT));

        // flush at iteration 10, together with a start (flush wins)
        held = u_if.result;
        u_if.start = 1'b1; u_if.funct3 = 3'b101; u_if.op_a = 32'd1000; u_if.op_b = 32'd3;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        u_if.flush = 1'b1; u_if.start = 1'b1; u_if.funct3 = 3'b101;
        u_if.op_a = 32'd8; u_if.op_b = 32'd2;
        @(posedge clk); #1;
        u_if.flush = 1'b0; u_if.start = 1'b0;
        check("flush_busy",   {31'd0, u_if.busy}, 32'd0);
        check("flush_done",   {31'd0, u_if.done}, 32'd0);
        check("flush_result", u_if.result, held);
        busy_n = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (u_if.done || u_if.busy) busy_n++;
        end
        check("flush_no_done", 32'(busy_n), 32'd0);
        do_op(3'b101, 32'd9, 32'd3, -1, lat, busy_n);
        check("post_flush_res", u_if.result, 32'd3);
        check("post_flush_lat", 32'(lat), 32'(DIV_LAT));

        // asynchronous reset mid-CALC, off the clock edge
        u_if.start = 1'b1; u_if.funct3 = 3'b100; u_if.op_a = 32'd77; u_if.op_b = 32'd5;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        check("pre_rst_busy", {31'd0, u_if.busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy",   {31'd0, u_if.busy}, 32'd0);
        check("arst_done",   {31'd0, u_if.done}, 32'd0);
        check("arst_result", u_if.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        do_op(3'b110, 32'd77, 32'd5, -1, lat, busy_n);
        check("post_rst_res", u_if.result, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
